// File: rtl/proc_bus_pkg.sv
// Shared definitions for the processor data bus: widths, legacy source codes,
// and the bus output state encoding.
package proc_bus_pkg;

  localparam int unsigned BUS_DATA_W  = 16;
  localparam int unsigned BUS_NUM_SRC = 9;
  localparam int unsigned LEGACY_W    = 4;

  localparam logic [LEGACY_W-1:0] SRC_RA = 4'd0;
  localparam logic [LEGACY_W-1:0] SRC_RB = 4'd1;
  localparam logic [LEGACY_W-1:0] SRC_RC = 4'd2;
  localparam logic [LEGACY_W-1:0] SRC_R1 = 4'd3;
  localparam logic [LEGACY_W-1:0] SRC_R2 = 4'd4;
  localparam logic [LEGACY_W-1:0] SRC_R3 = 4'd5;
  localparam logic [LEGACY_W-1:0] SRC_DR = 4'd6;
  localparam logic [LEGACY_W-1:0] SRC_AC = 4'd9;
  localparam logic [LEGACY_W-1:0] SRC_PC = 4'd10;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } bus_state_e;

  // Legacy codes 7 and 8 were unused, so AC/PC collapse down onto dense 7/8.
  function automatic logic [LEGACY_W-1:0] legacy_to_idx(input logic [LEGACY_W-1:0] code);
    return (code >= SRC_AC) ? LEGACY_W'(code - 4'd2) : code;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational request arbiter: round-robin from a pointer, or fixed
// lowest-index priority when ARB_RR is 0.
module rr_arbiter
#(
  parameter int unsigned NUM_SRC = 9,
  parameter int unsigned ARB_RR  = 1,
  parameter int unsigned SEL_W   = $clog2(NUM_SRC)
)
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   winner,
  output logic               any,
  output logic [NUM_SRC-1:0] gnt
);

  int base_c;

  // Scan offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    winner = '0;
    gnt    = '0;
    any    = |req;
    base_c = (ARB_RR != 0) ? int'(ptr) : 0;
    for (int k = int'(NUM_SRC) - 1; k >= 0; k--) begin
      int idx;
      idx = base_c + k;
      if (idx >= int'(NUM_SRC)) idx = idx - int'(NUM_SRC);
      if (req[idx]) winner = SEL_W'(idx);
    end
    if (any) gnt[winner] = 1'b1;
  end

endmodule

// File: rtl/bus_arb_mux.sv
// Registered bus source mux: forced select or arbitration loads one source
// word into a valid/ready output register with full throughput.
module bus_arb_mux
  import proc_bus_pkg::*;
#(
  parameter int unsigned DATA_W  = BUS_DATA_W,
  parameter int unsigned NUM_SRC = BUS_NUM_SRC,
  parameter int unsigned SEL_W   = $clog2(NUM_SRC),
  parameter int unsigned ARB_RR  = 1
)
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_req,
  output logic [NUM_SRC-1:0]        src_gnt,
  input  logic                      force_valid,
  input  logic [SEL_W-1:0]          force_sel,
  output logic [DATA_W-1:0]         bus_data,
  output logic [SEL_W-1:0]          bus_src,
  output logic                      bus_valid,
  input  logic                      bus_ready,
  output logic                      sel_err,
  output logic [15:0]               xfer_cnt
);

  localparam int unsigned CMP_W = SEL_W + 1;

  bus_state_e          state, state_nxt;
  logic [SEL_W-1:0]    ptr;
  logic [DATA_W-1:0]   words [NUM_SRC];

  logic [SEL_W-1:0]    arb_idx;
  logic                arb_any;
  logic [NUM_SRC-1:0]  arb_gnt;

  logic                load_c;
  logic                force_ok_c;
  logic                force_bad_c;
  logic                cand_c;
  logic                arb_load_c;
  logic [SEL_W-1:0]    cand_idx_c;

  always_comb begin
    for (int i = 0; i < int'(NUM_SRC); i++) words[i] = src_data[i*DATA_W +: DATA_W];
  end

  rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .ARB_RR  (ARB_RR),
    .SEL_W   (SEL_W)
  ) u_arb (
    .req    (src_req),
    .ptr    (ptr),
    .winner (arb_idx),
    .any    (arb_any),
    .gnt    (arb_gnt)
  );

  assign force_ok_c  = force_valid && ({1'b0, force_sel} < CMP_W'(NUM_SRC));
  assign force_bad_c = force_valid && !force_ok_c;
  assign bus_valid   = (state == FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  // Candidate selection: valid force beats arbitration; a bad force falls through.
  always_comb begin
    state_nxt  = state;
    src_gnt    = '0;
    cand_c     = 1'b0;
    arb_load_c = 1'b0;
    cand_idx_c = arb_idx;
    load_c     = (state == EMPTY) || bus_ready;
    if (load_c) begin
      if (force_ok_c) begin
        cand_c              = 1'b1;
        cand_idx_c          = force_sel;
        src_gnt[force_sel]  = src_req[force_sel];
      end else if (arb_any) begin
        cand_c     = 1'b1;
        arb_load_c = 1'b1;
        src_gnt    = arb_gnt;
      end
      state_nxt = cand_c ? FULL : EMPTY;
    end
    if (!rst_n) src_gnt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_data <= '0;
      bus_src  <= '0;
      ptr      <= '0;
      sel_err  <= 1'b0;
      xfer_cnt <= 16'd0;
    end else begin
      if (cand_c) begin
        bus_data <= words[cand_idx_c];
        bus_src  <= cand_idx_c;
      end
      if (arb_load_c) begin
        ptr <= (arb_idx == SEL_W'(NUM_SRC - 1)) ? '0 : SEL_W'(arb_idx + SEL_W'(1));
      end
      sel_err <= load_c && force_bad_c;
      if (bus_valid && bus_ready) xfer_cnt <= xfer_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_bus_arb_mux.sv
// Directed and randomized bench for bus_arb_mux against a cycle-level
// reference model of the bus register, arbiter pointer and counter.
module tb_bus_arb_mux;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned NUM_SRC = 9;
  localparam int unsigned SEL_W   = 4;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC-1:0]        src_req;
  logic [NUM_SRC-1:0]        src_gnt;
  logic                      force_valid;
  logic [SEL_W-1:0]          force_sel;
  logic [DATA_W-1:0]         bus_data;
  logic [SEL_W-1:0]          bus_src;
  logic                      bus_valid;
  logic                      bus_ready;
  logic                      sel_err;
  logic [15:0]               xfer_cnt;

  logic [DATA_W-1:0] words [NUM_SRC];

  int n_cmp = 0;
  int n_err = 0;

  bit          m_valid;
  logic [15:0] m_data;
  int          m_src;
  int          m_ptr;
  logic [15:0] m_cnt;
  bit          m_err;

  bus_arb_mux dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .src_data    (src_data),
    .src_req     (src_req),
    .src_gnt     (src_gnt),
    .force_valid (force_valid),
    .force_sel   (force_sel),
    .bus_data    (bus_data),
    .bus_src     (bus_src),
    .bus_valid   (bus_valid),
    .bus_ready   (bus_ready),
    .sel_err     (sel_err),
    .xfer_cnt    (xfer_cnt)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < int'(NUM_SRC); i++) src_data[i*DATA_W +: DATA_W] = words[i];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_src   = 0;
    m_ptr   = 0;
    m_cnt   = '0;
    m_err   = 1'b0;
  endtask

  // One clock: predict grant before the edge, then predict registered outputs.
  task automatic step();
    logic [NUM_SRC-1:0] eg;
    logic [15:0]        ndata;
    bit                 load, fok, have, acc;
    int                 cand, nptr, k;
    @(negedge clk);
    load = !m_valid || bus_ready;
    fok  = force_valid && (int'(force_sel) < int'(NUM_SRC));
    acc  = m_valid && bus_ready;
    eg   = '0;
    have = 1'b0;
    cand = 0;
    nptr = m_ptr;
    if (load) begin
      if (fok) begin
        cand     = int'(force_sel);
        have     = 1'b1;
        eg[cand] = src_req[cand];
      end else if (src_req != '0) begin
        k = 0;
        while (!src_req[(m_ptr + k) % NUM_SRC]) k++;
        cand     = (m_ptr + k) % NUM_SRC;
        have     = 1'b1;
        eg[cand] = 1'b1;
        nptr     = (cand + 1) % NUM_SRC;
      end
    end
    ndata = words[cand];
    check("src_gnt", 32'(src_gnt), 32'(eg));
    @(posedge clk);
    m_err = load && force_valid && !fok;
    if (acc) m_cnt = m_cnt + 16'd1;
    if (load) m_valid = have;
    if (have) begin
      m_data = ndata;
      m_src  = cand;
    end
    m_ptr = nptr;
    #1;
    check("bus_valid", 32'(bus_valid), 32'(m_valid));
    check("bus_data",  32'(bus_data),  32'(m_data));
    check("bus_src",   32'(bus_src),   32'(m_src));
    check("sel_err",   32'(sel_err),   32'(m_err));
    check("xfer_cnt",  32'(xfer_cnt),  32'(m_cnt));
  endtask

  initial begin
    int          seq [6];
    logic [15:0] held;
    int          n;

    seq = '{0, 1, 3, 0, 1, 3};
    rst_n       = 1'b0;
    src_req     = '0;
    force_valid = 1'b0;
    force_sel   = '0;
    bus_ready   = 1'b0;
    for (int i = 0; i < int'(NUM_SRC); i++) words[i] = 16'(i * 16'h1111);
    model_reset();

    #12;
    check("rst_valid", 32'(bus_valid), 32'd0);
    check("rst_data",  32'(bus_data),  32'd0);
    check("rst_src",   32'(bus_src),   32'd0);
    check("rst_err",   32'(sel_err),   32'd0);
    check("rst_cnt",   32'(xfer_cnt),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Idle bus after reset.
    repeat (10) step();

    // Forced select of DR with immediate accept.
    words[6]    = 16'hBEEF;
    force_valid = 1'b1;
    force_sel   = 4'd6;
    bus_ready   = 1'b1;
    step();
    check("force_data", 32'(bus_data), 32'h0000BEEF);
    check("force_src",  32'(bus_src),  32'd6);
    force_valid = 1'b0;
    step();
    check("first_accept", 32'(xfer_cnt), 32'd1);

    // Round-robin over sources 0,1,3.
    src_req = 9'h00B;
    for (int i = 0; i < 6; i++) begin
      step();
      check("rr_seq", 32'(bus_src), 32'(seq[i]));
    end

    // Backpressure: word held while sources churn.
    src_req   = '1;
    bus_ready = 1'b0;
    held      = bus_data;
    for (int i = 0; i < 5; i++) begin
      words[$urandom_range(0, NUM_SRC - 1)] = 16'($urandom);
      step();
      check("stall_hold", 32'(bus_data), 32'(held));
    end
    bus_ready = 1'b1;
    step();

    // Out-of-range force falls back to arbitration.
    src_req     = 9'h004;
    force_valid = 1'b1;
    force_sel   = 4'd15;
    step();
    check("bad_force_err", 32'(sel_err), 32'd1);
    check("bad_force_src", 32'(bus_src), 32'd2);
    force_valid = 1'b0;
    src_req     = 9'h012;
    step();
    check("ptr_after_2", 32'(bus_src), 32'd4);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      src_req     = NUM_SRC'($urandom);
      force_valid = ($urandom_range(0, 3) == 0);
      force_sel   = SEL_W'($urandom_range(0, 15));
      bus_ready   = ($urandom_range(0, 3) != 0);
      words[$urandom_range(0, NUM_SRC - 1)] = 16'($urandom);
      step();
    end

    // Async reset while FULL with the pointer parked at 5.
    force_valid = 1'b0;
    bus_ready   = 1'b1;
    src_req     = 9'h010;
    step();
    src_req   = '0;
    bus_ready = 1'b0;
    step();
    @(posedge clk);
    #2;
    rst_n   = 1'b0;
    src_req = 9'h041;
    #1;
    check("async_valid", 32'(bus_valid), 32'd0);
    check("async_data",  32'(bus_data),  32'd0);
    check("async_cnt",   32'(xfer_cnt),  32'd0);
    check("async_gnt",   32'(src_gnt),   32'd0);
    model_reset();
    #1;
    rst_n     = 1'b1;
    bus_ready = 1'b1;
    step();
    check("post_rst_winner", 32'(bus_src), 32'd0);

    // Counter wrap under sustained forced traffic.
    src_req     = '0;
    force_valid = 1'b1;
    force_sel   = 4'd0;
    step();
    n = 16'hFFFF - int'(m_cnt);
    repeat (n) @(posedge clk);
    #1;
    m_cnt  = 16'(int'(m_cnt) + n);
    m_data = words[0];
    m_src  = 0;
    check("cnt_ffff", 32'(xfer_cnt), 32'h0000FFFF);
    step();
    check("cnt_wrap", 32'(xfer_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bus_arb_mux.md
Name: bus_arb_mux

Overview:
- Parametrised, registered successor to the processor's combinational bus source mux.
- Selects one of NUM_SRC register/datapath sources onto the shared data bus.
- Selection is either a forced select code from the control unit or arbitration between requesters (fixed priority or round-robin).
- Output register holds data under a valid/ready handshake until the consumer (ALU/AC/memory path) accepts it.

Parameters:
- DATA_W, 16, width of each source and of the bus.
- NUM_SRC, 9, number of sources, index 0..NUM_SRC-1.
- SEL_W, $clog2(NUM_SRC), width of the select and source-ID fields.
- ARB_RR, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- src_data  in  NUM_SRC*DATA_W  packed source words; source i occupies [i*DATA_W +: DATA_W].
- src_req  in  NUM_SRC  per-source request, level, held until granted.
- src_gnt  out  NUM_SRC  one-hot grant, combinational, asserted in the load cycle.
- force_valid  in  1  control-unit forced select present.
- force_sel  in  SEL_W  forced source index.
- bus_data  out  DATA_W  registered bus word.
- bus_src  out  SEL_W  index of the source currently on the bus.
- bus_valid  out  1  bus word valid.
- bus_ready  in  1  consumer accepts the word.
- sel_err  out  1  one-cycle registered pulse on an out-of-range forced select.
- xfer_cnt  out  16  wrapping count of accepted transfers.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values (asserted asynchronously, independent of clk):
  - bus_data=0, bus_src=0, bus_valid=0, sel_err=0, xfer_cnt=0.
  - RR pointer=0; state=EMPTY.
- States:
  - EMPTY (bus_valid=0).
  - FULL (bus_valid=1).
- load = (state==EMPTY) | (state==FULL & bus_ready). Full throughput: back-to-back loads are possible every cycle.
- Candidate selection when load=1, in priority order:
  1. force_valid & force_sel<NUM_SRC: candidate=force_sel. Loaded even if src_req[force_sel]=0. src_gnt[force_sel]=src_req[force_sel].
  2. force_valid & force_sel>=NUM_SRC: force is ignored, sel_err=1 next cycle, and arbitration (rule 3) proceeds in the same cycle.
  3. No valid force, |src_req: arbiter winner.
     - Fixed mode: lowest requesting index.
     - RR mode: first requester at or after the pointer, wrapping at NUM_SRC-1 to 0.
  4. No force and no request: no load.
- On a load:
  - Next edge: bus_data=src_data[candidate], bus_src=candidate, bus_valid=1, state=FULL.
  - src_gnt is one-hot for the winner in the load cycle. The source drops or keeps its req the next cycle; a kept req is a new request.
  - RR pointer becomes (candidate+1) mod NUM_SRC only for arbitrated loads. Forced loads leave the pointer unchanged.
- Without a load:
  - FULL & !bus_ready: bus_data and bus_src are held stable. src_gnt=0 regardless of req or force.
  - FULL & bus_ready & no candidate: bus_valid=0 next edge, state=EMPTY.
- Acceptance: xfer_cnt increments by 1 on every cycle with bus_valid & bus_ready, wrapping 0xFFFF to 0.
- Latency: req or force in cycle N with load=1 gives bus_valid in cycle N+1. Minimum one cycle; no combinational path from src_data to bus_data.
- Simultaneous events:
  - Accept and new load in the same cycle: the old word counts, the new word replaces it, bus_valid stays 1.
  - Force and request coincide: force wins; the requester stays pending.
- Reset mid-transfer: a held word is discarded, no grant is issued, and the pointer and counter clear.
- Simulation-only $display tracing is not permitted in this block.

Decomposition:
- Shared package proc_bus_pkg:
  - DATA_W default.
  - Source index localparams (SRC_RA=0, SRC_RB=1, SRC_RC=2, SRC_R1=3, SRC_R2=4, SRC_R3=5, SRC_DR=6, SRC_AC=9, SRC_PC=10 in the legacy code map). Legacy codes map to dense indices via a package function.
  - State enum {EMPTY, FULL}.
- Sub-module rr_arbiter (NUM_SRC, ARB_RR): inputs req and pointer; outputs winner index, any, and one-hot grant. Purely combinational.
- Top-level bus_arb_mux holds the state register, output register, pointer, sel_err and counter.

Test Plan:
1. Reset, then src_req=0 and no force -> bus_valid=0, xfer_cnt=0, src_gnt=0 for 10 cycles.
2. force_valid=1, force_sel=6, src_data[6]=16'hBEEF, bus_ready=1 -> bus_data=BEEF, bus_src=6, bus_valid=1 next cycle; xfer_cnt=1 after the accept cycle.
3. ARB_RR=1, src_req=9'h00B (sources 0,1,3) held, bus_ready=1 -> bus_src sequence 0,1,3,0,1,3 on consecutive cycles; one src_gnt per cycle.
4. FULL with bus_ready=0 for 5 cycles while src_data changes and src_req=all ones -> bus_data constant, src_gnt=0, xfer_cnt unchanged; bus_ready=1 -> next source loads in the same cycle.
5. force_valid=1, force_sel=15 with src_req[2]=1 -> sel_err pulses 1 cycle, bus_src=2, RR pointer=3.
6. rst_n low mid-FULL, asynchronous to clk -> bus_valid=0 immediately; after release, src_req[0]=1 wins even if pointer was 5 before reset; xfer_cnt wraps 0xFFFF to 0 under sustained traffic.
